// File: rtl/suma_display_7seg.sv
// Latches Num1+Num2 on each Sum_ready rise, converts it to BCD with a sequential
// double-dabble and scans the result onto a 4-digit 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (units always shown).
module suma_display_7seg #(
    parameter int NUM_W       = 10,
    parameter int REFRESH_DIV = 27000,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic             clk_27MHz,
    input  logic             reset,
    input  logic [NUM_W-1:0] Num1,
    input  logic [NUM_W-1:0] Num2,
    input  logic             Sum_ready,
    output logic [NUM_W:0]   sum_bin,
    output logic [15:0]      bcd,
    output logic             bcd_valid,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int SW   = NUM_W + 1;
    localparam int SR_W = 16 + SW;
    localparam int IT_W = $clog2(SW + 1);
    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = SEG_ACT_LOW ? 4'hF : 4'h0;

    logic            r_sr_d;
    logic [1:0]      r_state;
    logic [SR_W-1:0] r_shift;
    logic [IT_W-1:0] r_iter;
    logic [SW-1:0]   r_sum;
    logic [15:0]     r_bcd;
    logic            r_valid;
    logic [RC_W-1:0] r_refresh;
    logic [1:0]      r_digit;
    logic [6:0]      r_seg;
    logic [3:0]      r_an;

    logic            w_rise;
    logic [SW-1:0]   w_sum;
    logic [SR_W-1:0] w_adj;
    logic [SR_W-1:0] w_shifted;
    logic [1:0]      w_state_next;
    logic [SR_W-1:0] w_shift_next;
    logic [IT_W-1:0] w_iter_next;
    logic [SW-1:0]   w_sum_next;
    logic [15:0]     w_bcd_next;
    logic            w_valid_next;
    logic            w_wrap;
    logic [1:0]      w_digit_next;
    logic [3:0]      w_nib_sel;
    logic            w_blank;
    logic [6:0]      w_seg_hi;
    logic [3:0]      w_an_hot;
    logic [3:0]      w_digit_zero;

    assign w_rise = Sum_ready & ~r_sr_d;
    assign w_sum  = {1'b0, Num1} + {1'b0, Num2};

    // Double-dabble add-3 stage on each BCD nibble, binary part passes through.
    assign w_adj[SW-1:0] = r_shift[SW-1:0];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            logic [3:0] w_nib;
            assign w_nib = r_shift[SW + 4*gi +: 4];
            assign w_adj[SW + 4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
        end
    endgenerate
    assign w_shifted = {w_adj[SR_W-2:0], 1'b0};

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_iter_next  = r_iter;
        w_sum_next   = r_sum;
        w_bcd_next   = r_bcd;
        w_valid_next = r_valid;
        if (w_rise) begin
            // A rise in any state (including mid-conversion) starts a fresh run.
            w_sum_next   = w_sum;
            w_shift_next = {16'b0, w_sum};
            w_iter_next  = '0;
            w_valid_next = 1'b0;
            w_state_next = S_CONV;
        end else if (r_state == S_CONV) begin
            if (r_iter == IT_W'(SW)) begin
                w_bcd_next   = r_shift[SR_W-1 -: 16];
                w_valid_next = 1'b1;
                w_state_next = S_DONE;
            end else begin
                w_shift_next = w_shifted;
                w_iter_next  = r_iter + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_27MHz or posedge reset) begin
        if (reset) begin
            r_sr_d  <= 1'b0;
            r_state <= S_IDLE;
            r_shift <= '0;
            r_iter  <= '0;
            r_sum   <= '0;
            r_bcd   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sr_d  <= Sum_ready;
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_iter  <= w_iter_next;
            r_sum   <= w_sum_next;
            r_bcd   <= w_bcd_next;
            r_valid <= w_valid_next;
        end
    end

    assign w_wrap       = (r_refresh == RC_W'(REFRESH_DIV - 1));
    assign w_digit_next = w_wrap ? (r_digit + 2'd1) : r_digit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_zero
            assign w_digit_zero[gi] = (w_bcd_next[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // Display decode works from next-cycle values so seg/an track bcd_valid exactly.
    always_comb begin
        w_nib_sel = w_bcd_next[4*w_digit_next +: 4];
        w_an_hot  = 4'b0001 << w_digit_next;
        w_blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (w_digit_next)
            2'd3:    w_blank = w_digit_zero[3];
            2'd2:    w_blank = w_digit_zero[3] & w_digit_zero[2];
            2'd1:    w_blank = w_digit_zero[3] & w_digit_zero[2] & w_digit_zero[1];
            default: w_blank = 1'b0;
        endcase
`else
        w_blank   = 1'b0;
`endif
        case (w_nib_sel)
            4'd0:    w_seg_hi = 7'h3F;
            4'd1:    w_seg_hi = 7'h06;
            4'd2:    w_seg_hi = 7'h5B;
            4'd3:    w_seg_hi = 7'h4F;
            4'd4:    w_seg_hi = 7'h66;
            4'd5:    w_seg_hi = 7'h6D;
            4'd6:    w_seg_hi = 7'h7D;
            4'd7:    w_seg_hi = 7'h07;
            4'd8:    w_seg_hi = 7'h7F;
            4'd9:    w_seg_hi = 7'h6F;
            default: w_seg_hi = 7'h00;
        endcase
        if (w_blank) begin
            w_seg_hi = 7'h00;
        end
    end

    always_ff @(posedge clk_27MHz or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_digit   <= 2'd0;
            r_seg     <= SEG_OFF;
            r_an      <= AN_OFF;
        end else begin
            r_refresh <= w_wrap ? '0 : (r_refresh + 1'b1);
            r_digit   <= w_digit_next;
            if (w_valid_next) begin
                r_seg <= SEG_ACT_LOW ? ~w_seg_hi : w_seg_hi;
                r_an  <= SEG_ACT_LOW ? ~w_an_hot : w_an_hot;
            end else begin
                r_seg <= SEG_OFF;
                r_an  <= AN_OFF;
            end
        end
    end

    assign sum_bin   = r_sum;
    assign bcd       = r_bcd;
    assign bcd_valid = r_valid;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule

// File: tb/tb_suma_display_7seg.sv
// Scoreboard bench for suma_display_7seg: sums, BCD latency, display scan,
// abort-on-rise and mid-conversion reset.
module tb_suma_display_7seg;

    localparam int NUM_W = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NUM_W-1:0] Num1 = '0;
    logic [NUM_W-1:0] Num2 = '0;
    logic             Sum_ready = 1'b0;
    logic [NUM_W:0]   sum_bin;
    logic [15:0]      bcd;
    logic             bcd_valid;
    logic [6:0]       seg;
    logic [3:0]       an;

    typedef struct {
        logic [NUM_W:0] sum;
        logic [15:0]    bcd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    suma_display_7seg #(
        .NUM_W(NUM_W),
        .REFRESH_DIV(4),
        .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk_27MHz(clk),
        .reset(reset),
        .Num1(Num1),
        .Num2(Num2),
        .Sum_ready(Sum_ready),
        .sum_bin(sum_bin),
        .bcd(bcd),
        .bcd_valid(bcd_valid),
        .seg(seg),
        .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (n < 4'd10) ? tbl[n] : 7'h00;
    endfunction

    // Expected active-low segment pattern for digit slot d of value b.
    function automatic logic [6:0] exp_seg(input logic [15:0] b, input int d);
        logic [6:0] s;
        s = seg_code(b[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 3 && b[15:12] == 0) s = 7'h00;
        if (d == 2 && b[15:8] == 0)  s = 7'h00;
        if (d == 1 && b[15:4] == 0)  s = 7'h00;
`endif
        return ~s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise Sum_ready after at least one low sample; returns just after the sampling edge.
    task automatic start_rise(input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] b);
        exp_t e;
        tick();
        Sum_ready = 1'b0;
        Num1 = a;
        Num2 = b;
        tick();
        Sum_ready = 1'b1;
        e.sum = {1'b0, a} + {1'b0, b};
        e.bcd = to_bcd(int'(a) + int'(b));
        sb.push_back(e);
        tick();
    endtask

    task automatic run_sum(input logic [NUM_W-1:0] a, input logic [NUM_W-1:0] b);
        exp_t e;
        int   cyc;
        start_rise(a, b);
        n_cmp++;
        if (bcd_valid !== 1'b0 || an !== 4'hF) begin
            n_err++;
            $display("FAIL start_gate: valid=%b an=%b required valid=0 an=1111", bcd_valid, an);
        end
        cyc = 0;
        while (bcd_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        Sum_ready = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (cyc !== 12) begin
            n_err++;
            $display("FAIL latency: got %0d clocks required 12", cyc);
        end
        n_cmp++;
        if (sum_bin !== e.sum) begin
            n_err++;
            $display("FAIL sum_bin: got %0d required %0d", sum_bin, e.sum);
        end
        n_cmp++;
        if (bcd !== e.bcd) begin
            n_err++;
            $display("FAIL bcd: got %h required %h", bcd, e.bcd);
        end
        $display("txn %0d+%0d -> sum_bin=%0d bcd=%h latency=%0d", a, b, sum_bin, bcd, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            n_err++;
            $display("FAIL reset_display: an=%b seg=%b required 1111/1111111", an, seg);
        end
        n_cmp++;
        if (bcd_valid !== 1'b0 || sum_bin !== '0 || bcd !== 16'h0) begin
            n_err++;
            $display("FAIL reset_regs: valid=%b sum=%0d bcd=%h required 0/0/0000", bcd_valid, sum_bin, bcd);
        end
        $display("txn reset an=%b seg=%b valid=%b", an, seg, bcd_valid);
        #2 reset = 1'b0;
    endtask

    task automatic test_sums();
        run_sum(10'd123, 10'd456);
        run_sum(10'd999, 10'd999);
        run_sum(10'd1023, 10'd1023);
        run_sum(10'd0, 10'd0);
    endtask

    task automatic test_display();
        int cyc;
        logic [15:0] val;
        run_sum(10'd123, 10'd456);
        val = 16'h0579;
        cyc = 0;
        while (an !== 4'b0111 && cyc < 40) begin tick(); cyc++; end
        while (an !== 4'b1110 && cyc < 40) begin tick(); cyc++; end
        n_cmp++;
        if (cyc >= 40) begin
            n_err++;
            $display("FAIL scan_sync: an=%b never reached 1110", an);
        end
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (an !== ~(4'b0001 << s) || seg !== exp_seg(val, s)) begin
                    n_err++;
                    $display("FAIL scan slot%0d cyc%0d: an=%b seg=%h required an=%b seg=%h",
                             s, c, an, seg, ~(4'b0001 << s), exp_seg(val, s));
                end
                tick();
            end
            $display("txn scan slot%0d seg=%h", s, exp_seg(val, s));
        end
        Sum_ready = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (bcd_valid !== 1'b1 || bcd !== val) begin
            n_err++;
            $display("FAIL hold_after_fall: valid=%b bcd=%h required 1/%h", bcd_valid, bcd, val);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int cyc;
        int changed;
        logic [15:0] old_bcd;
        old_bcd = bcd;
        start_rise(10'd1000, 10'd1000);
        repeat (4) tick();
        n_cmp++;
        if (bcd_valid !== 1'b0 || bcd !== old_bcd || an !== 4'hF) begin
            n_err++;
            $display("FAIL conv_hold: valid=%b bcd=%h an=%b required 0/%h/1111", bcd_valid, bcd, an, old_bcd);
        end
        Sum_ready = 1'b0;
        Num1 = 10'd1;
        Num2 = 10'd2;
        tick();
        Sum_ready = 1'b1;
        void'(sb.pop_back());
        e.sum = 11'd3;
        e.bcd = 16'h0003;
        sb.push_back(e);
        tick();
        cyc = 0;
        changed = 0;
        while (bcd_valid !== 1'b1 && cyc < 40) begin
            if (bcd !== old_bcd) changed = 1;
            tick();
            cyc++;
        end
        Sum_ready = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (changed !== 0) begin
            n_err++;
            $display("FAIL abort_write: bcd changed before valid, required hold %h", old_bcd);
        end
        n_cmp++;
        if (cyc !== 12 || bcd !== e.bcd || sum_bin !== e.sum) begin
            n_err++;
            $display("FAIL abort_result: lat=%0d bcd=%h sum=%0d required 12/%h/%0d", cyc, bcd, sum_bin, e.bcd, e.sum);
        end
        $display("txn abort -> sum_bin=%0d bcd=%h latency=%0d", sum_bin, bcd, cyc);
    endtask

    task automatic test_reset_mid();
        start_rise(10'd500, 10'd400);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        void'(sb.pop_back());
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || bcd_valid !== 1'b0 || sum_bin !== '0 || bcd !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid: an=%b seg=%b valid=%b sum=%0d bcd=%h required reset values",
                     an, seg, bcd_valid, sum_bin, bcd);
        end
        $display("txn reset mid-conversion");
        #2 reset = 1'b0;
        Sum_ready = 1'b0;
        run_sum(10'd500, 10'd400);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_sum(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
        end
    endtask

    initial begin
        test_reset();
        test_sums();
        test_display();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
